// File: rtl/wb_queue.sv
// Writeback queue: DEPTH-entry FIFO of (rd, data) results that drains into the register-file write port.
// Define WB_QUEUE_FWD_EN to build the youngest-match bypass mux; otherwise fwd0_data/fwd1_data are tied to 0.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rd,
    input  logic [XLEN-1:0]          in_data,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic                     rf_ready,
    input  logic [AW-1:0]            raddr0,
    input  logic [AW-1:0]            raddr1,
    output logic                     pend0,
    output logic                     pend1,
    output logic [XLEN-1:0]          fwd0_data,
    output logic [XLEN-1:0]          fwd1_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt_q;
    logic [AW-1:0]   q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic hit0;
    logic hit1;
    logic [PW-1:0] idx_p;

    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign in_ready = rst_n & ~full;
    assign push     = in_valid & in_ready & (in_rd != '0);
    assign rf_we    = rst_n & (cnt_q != '0);
    assign rf_waddr = q_rd[rd_ptr];
    assign rf_wdata = q_data[rd_ptr];
    assign pop      = rf_we & rf_ready;
    assign count    = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; validity is derived purely from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            q_rd[wr_ptr]   <= in_rd;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        hit0  = 1'b0;
        hit1  = 1'b0;
        idx_p = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_p = rd_ptr + PW'(k);
            if ((PW+1)'(k) < cnt_q) begin
                if (q_rd[idx_p] == raddr0)
                    hit0 = 1'b1;
                if (q_rd[idx_p] == raddr1)
                    hit1 = 1'b1;
            end
        end
    end

    assign pend0 = rst_n & (raddr0 != '0) & hit0;
    assign pend1 = rst_n & (raddr1 != '0) & hit1;

`ifdef WB_QUEUE_FWD_EN
    logic [XLEN-1:0] sel0;
    logic [XLEN-1:0] sel1;
    logic [PW-1:0]   idx_f;

    // Walk from oldest (offset 0 from rd_ptr) to youngest so later matches override earlier ones.
    always_comb begin
        sel0  = '0;
        sel1  = '0;
        idx_f = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_f = rd_ptr + PW'(k);
            if ((PW+1)'(k) < cnt_q) begin
                if (q_rd[idx_f] == raddr0)
                    sel0 = q_data[idx_f];
                if (q_rd[idx_f] == raddr1)
                    sel1 = q_data[idx_f];
            end
        end
    end

    assign fwd0_data = pend0 ? sel0 : '0;
    assign fwd1_data = pend1 ? sel1 : '0;
`else
    assign fwd0_data = '0;
    assign fwd1_data = '0;
`endif

endmodule
